// File: rtl/ultrasonic_sequencer.sv
// Two-channel ultrasonic ranging sequencer.
// Fires a trigger pulse on the selected sensor, times the echo pulse width and
// presents the result on d/ch/timeout with a valid/ack handshake. After each
// accepted result a holdoff interval elapses; the first channel is followed
// automatically by the second, after which the block returns to idle.
//
// Optional feature macro: US_AUTO_RUN_EN -- when defined, the block starts a new
// pair by itself after HOLDOFF_CYCLES of idle time (start still starts at once).
//
// Ports:
//   CLKOUTD  clock, all state updates on its rising edge
//   reset    synchronous active-low reset
//   start    level request to run one measurement pair
//   ECHO0/1  pre-synchronised echo lines of sensors 0 and 1
//   ack      consumer acceptance of the current result
//   TRIG0/1  registered trigger pulses to sensors 0 and 1
//   d        measured echo width in cycles (cm)
//   ch       channel that produced d
//   valid    result on d/ch/timeout is held and valid
//   timeout  result is a fault (no echo rise, or width saturated)
//   busy     high whenever the sequencer is not idle
module ultrasonic_sequencer #(
  parameter int unsigned TRIG_CYCLES    = 10,
  parameter int unsigned RISE_TIMEOUT   = 200,
  parameter int unsigned HOLDOFF_CYCLES = 600
) (
  input  logic       CLKOUTD,
  input  logic       reset,
  input  logic       start,
  input  logic       ECHO0,
  input  logic       ECHO1,
  input  logic       ack,
  output logic       TRIG0,
  output logic       TRIG1,
  output logic [7:0] d,
  output logic       ch,
  output logic       valid,
  output logic       timeout,
  output logic       busy
);

  typedef enum logic [2:0] {
    StIdle, StTrig, StWaitRise, StMeasure, StReport, StHoldoff
  } state_e;

  // Terminal values of the shared phase timer (timer counts 0..N-1).
  localparam logic [15:0] TrigLast = 16'(TRIG_CYCLES - 1);
  localparam logic [15:0] RiseLast = 16'(RISE_TIMEOUT - 1);
  localparam logic [15:0] HoldLast = 16'(HOLDOFF_CYCLES - 1);

  state_e      state_q, state_d;
  logic        sel_q, sel_d;
  logic [15:0] timer_q, timer_d;
  logic [7:0]  meas_q, meas_d;
  logic [7:0]  d_q, d_d;
  logic        ch_q, ch_d;
  logic        valid_q, valid_d;
  logic        timeout_q, timeout_d;
  logic        trig0_q, trig0_d;
  logic        trig1_q, trig1_d;
  logic        echo_sel;

`ifdef US_AUTO_RUN_EN
  logic [15:0] idle_q, idle_d;
`endif

  assign echo_sel = sel_q ? ECHO1 : ECHO0;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    timer_d   = timer_q + 16'd1;
    meas_d    = meas_q;
    d_d       = d_q;
    ch_d      = ch_q;
    valid_d   = valid_q;
    timeout_d = timeout_q;
`ifdef US_AUTO_RUN_EN
    idle_d    = '0;
`endif

    unique case (state_q)
      StIdle: begin
        timer_d = '0;
`ifdef US_AUTO_RUN_EN
        idle_d = idle_q + 16'd1;
        if (start || idle_q == HoldLast) begin
          state_d = StTrig;
          idle_d  = '0;
        end
`else
        if (start) begin
          state_d = StTrig;
        end
`endif
      end
      StTrig: begin
        if (timer_q == TrigLast) begin
          state_d = StWaitRise;
          timer_d = '0;
        end
      end
      StWaitRise: begin
        // A rise on the final allowed cycle still wins over the timeout.
        if (echo_sel) begin
          state_d = StMeasure;
          meas_d  = 8'd1;
          timer_d = '0;
        end else if (timer_q == RiseLast) begin
          state_d   = StReport;
          d_d       = 8'd0;
          ch_d      = sel_q;
          timeout_d = 1'b1;
          valid_d   = 1'b1;
        end
      end
      StMeasure: begin
        timer_d = '0;
        if (!echo_sel) begin
          state_d   = StReport;
          d_d       = meas_q;
          ch_d      = sel_q;
          timeout_d = 1'b0;
          valid_d   = 1'b1;
        end else if (meas_q == 8'hff) begin
          // Echo still high past full scale: report saturation, ignore the rest.
          state_d   = StReport;
          d_d       = 8'hff;
          ch_d      = sel_q;
          timeout_d = 1'b1;
          valid_d   = 1'b1;
        end else begin
          meas_d = meas_q + 8'd1;
        end
      end
      StReport: begin
        timer_d = '0;
        if (ack && valid_q) begin
          state_d = StHoldoff;
          valid_d = 1'b0;
          sel_d   = ~sel_q;
        end
      end
      StHoldoff: begin
        if (timer_q == HoldLast) begin
          timer_d = '0;
          // sel is 1 here only after channel 0 finished: run channel 1 next.
          state_d = sel_q ? StTrig : StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Triggers are decoded from the next state so the outputs are registered.
    trig0_d = (state_d == StTrig) && !sel_d;
    trig1_d = (state_d == StTrig) && sel_d;
  end

  always_ff @(posedge CLKOUTD) begin
    if (!reset) begin
      state_q   <= StIdle;
      sel_q     <= 1'b0;
      timer_q   <= '0;
      meas_q    <= '0;
      d_q       <= '0;
      ch_q      <= 1'b0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      trig0_q   <= 1'b0;
      trig1_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      timer_q   <= timer_d;
      meas_q    <= meas_d;
      d_q       <= d_d;
      ch_q      <= ch_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      trig0_q   <= trig0_d;
      trig1_q   <= trig1_d;
    end
  end

`ifdef US_AUTO_RUN_EN
  always_ff @(posedge CLKOUTD) begin
    if (!reset) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`endif

  assign TRIG0   = trig0_q;
  assign TRIG1   = trig1_q;
  assign d       = d_q;
  assign ch      = ch_q;
  assign valid   = valid_q;
  assign timeout = timeout_q;
  assign busy    = (state_q != StIdle);

endmodule

// File: doc/ultrasonic_sequencer.md
ULTRASONIC_SEQUENCER -- requirements
Module: ultrasonic_sequencer

Interface
REQ-001 Parameter TRIG_CYCLES, default 10: trigger pulse width in CLKOUTD cycles (1..255).
REQ-002 Parameter RISE_TIMEOUT, default 200: max cycles from trigger end to echo rise (1..65535).
REQ-003 Parameter HOLDOFF_CYCLES, default 600: dead time after each measurement before the next trigger (1..65535).
REQ-004 CLKOUTD  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; sampled on the CLKOUTD rising edge; 0 = reset.
REQ-006 start  input  1  level request to run one measurement cycle over both channels.
REQ-007 ECHO0, ECHO1  input  1 each  echo lines of sensors 0 and 1; pre-synchronised.
REQ-008 TRIG0, TRIG1  output  1 each  trigger pulses to sensors 0 and 1.
REQ-009 d  output  8  measured echo width in cycles (distance in cm).
REQ-010 ch  output  1  channel that produced d.
REQ-011 valid  output  1  result on d/ch/timeout is held and valid.
REQ-012 ack  input  1  consumer acceptance of the current result.
REQ-013 timeout  output  1  result is a fault: no echo rise, or echo width saturated.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 FSM states SHALL be IDLE, TRIG, WAIT_RISE, MEASURE, REPORT, HOLDOFF.
REQ-016 IDLE -> TRIG when start=1; channel pointer sel is used as is, with no change.
REQ-017 TRIG: TRIG[sel]=1 for exactly TRIG_CYCLES cycles; the other TRIG stays 0; then -> WAIT_RISE.
REQ-018 WAIT_RISE: ECHO[sel]=1 -> MEASURE, with count cleared to 1 in the same edge; no rise within RISE_TIMEOUT cycles -> REPORT with d=0, timeout=1.
REQ-019 MEASURE: count +1 per cycle while ECHO[sel]=1; ECHO[sel]=0 -> REPORT with d=count, timeout=0.
REQ-020 Count saturates at 255; reaching 255 with echo still high -> REPORT with d=255, timeout=1; remainder of echo ignored.
REQ-021 REPORT: valid=1; d, ch=sel, and timeout held stable until ack=1 is sampled.
REQ-022 ack with valid=1: valid drops on the next edge; -> HOLDOFF; sel toggles in the same edge.
REQ-023 ack while valid=0 SHALL be ignored.
REQ-024 HOLDOFF: wait HOLDOFF_CYCLES; then -> TRIG if sel=1 (second channel pending), else -> IDLE (pair complete).
REQ-025 start is ignored outside IDLE; deasserting start mid-cycle does not abort the cycle.
REQ-026 Echo activity on the non-selected channel SHALL be ignored.
REQ-027 TRIG outputs SHALL be registered and glitch-free; both TRIG outputs are never high together.
REQ-028 Latency: falling echo edge -> valid=1 on the next CLKOUTD edge.

Reset
REQ-029 reset=0 at any edge, in any state, SHALL force the following on that edge: state=IDLE, sel=0, TRIG0=TRIG1=0, d=0, ch=0, valid=0, timeout=0, busy=0, all counters=0.
REQ-030 Reset mid-TRIG SHALL truncate the trigger pulse immediately.
REQ-031 A pending result lost to reset SHALL not reappear.

Configuration
REQ-032 Macro US_AUTO_RUN_EN defined: from IDLE the block self-starts a new pair after HOLDOFF_CYCLES of idle; the start input still triggers an immediate start.
REQ-033 Macro US_AUTO_RUN_EN undefined: measurements occur only on start; the idle counter is not synthesised.

Verification
REQ-034 start=1, ECHO0 high 37 cycles after a 5-cycle delay -> TRIG0 high 10 cycles, then valid=1, d=37, ch=0, timeout=0.
REQ-035 ECHO1 never rises -> after 200 cycles in WAIT_RISE: valid=1, d=0, ch=1, timeout=1.
REQ-036 ECHO0 held high 400 cycles -> d=255, timeout=1; no further state change until ack.
REQ-037 ack withheld 1000 cycles -> d/ch/valid stable throughout; ack=1 -> valid=0 next edge; next TRIG1 fires after 600 cycles.
REQ-038 reset=0 for 1 cycle mid-MEASURE -> all outputs 0 on that edge, busy=0; a new start yields a correct result on ch=0.
REQ-039 US_AUTO_RUN_EN defined, start=0 -> pairs repeat every measurement-plus-holdoff period; ch alternates 0,1,0,1.
